exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Cycle-level sequencer for the single-cycle MIPS core. It gates PC advance and register-file write so that data-memory accesses can take a variable number of cycles through a req/ready handshake. It also provides halt, single-step and memory-timeout fault control, plus retired-instruction and stall-cycle counters. It sits between the control unit's decoded signals and the datapath's `RegWrite` input and PC register load enable.

## Interface
- `TIMEOUT`, default 16: maximum MEM_WAIT cycles before fault; legal range 1..255.
- `CNT_W`, default 32: width of both counters.
- `START_RUN`, default 1: state after reset; 1 = RUN, 0 = HALT.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MemRead` in 1: decoded load (the control unit's MemtoReg).
- `MemWrite` in 1: decoded store.
- `RegWriteIn` in 1: decoded register write.
- `MemReady` in 1: data memory completes the current access this cycle.
- `HaltReq` in 1: level request to stop at the next instruction boundary.
- `StepReq` in 1: pulse; in HALT, execute exactly one instruction.
- `PCEn` out 1: PC register load enable.
- `RegWriteEn` out 1: drives the datapath register-file WE3.
- `MemReq` out 1: data-memory access request.
- `MemWE` out 1: write qualifier, valid with `MemReq`.
- `Halted` out 1: state is HALT.
- `Fault` out 1: state is FAULT.
- `RetireCount` out CNT_W: instructions committed.
- `StallCount` out CNT_W: cycles spent in MEM_WAIT.

## Operation
- States: HALT, RUN, STEP, MEM_WAIT, FAULT. `memop = MemRead | MemWrite`.
- Commit cycle: `PCEn=1`, `RegWriteEn=RegWriteIn`, `RetireCount+1`. No other cycle asserts `PCEn` or `RegWriteEn`.
- RUN or STEP with `!memop`: commit in that cycle.
- RUN or STEP with `memop`:
  - `MemReq=1` and `MemWE=MemWrite`.
  - If `MemReady=1`, commit in the same cycle.
  - Otherwise latch the origin (RUN or STEP) and go to MEM_WAIT with `waitcnt=1`.
- MEM_WAIT:
  - `MemReq` stays 1 and `MemWE` stays equal to `MemWrite`. Decoded inputs are stable because PC is frozen.
  - `StallCount+1` every cycle.
  - `MemReady=1`: commit, then return toward the origin state.
  - `MemReady=0` and `waitcnt==TIMEOUT`: go to FAULT.
  - Otherwise `waitcnt+1`.
- After a commit:
  - Next state is HALT if `HaltReq=1` or the origin was STEP; otherwise RUN.
  - `HaltReq` is sampled only at commit. An access in flight is never aborted.
- RUN with `!memop` and `HaltReq=1`: the instruction commits, then the sequencer enters HALT.
- HALT:
  - All enables are 0.
  - `StepReq=1` goes to STEP.
  - `HaltReq=0` goes to RUN.
  - If both apply, `StepReq` wins.
- FAULT: all enables are 0. The only exit is reset.
- Counters wrap modulo 2^CNT_W without saturation.
- `StepReq` outside HALT is ignored.

## Timing
- Reset (synchronous): state=START_RUN?RUN:HALT, `waitcnt=0`, counters=0.
  - During the reset cycle, `PCEn`, `RegWriteEn`, `MemReq` and `MemWE` are all forced 0.
- `PCEn`, `RegWriteEn`, `MemReq` and `MemWE` are combinational from state and inputs (Mealy).
- `Halted`, `Fault` and the counters are registered.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction with `MemReady` in the request cycle: 1 cycle.
  - Memory instruction with `MemReady` arriving k cycles later: 1+k cycles, with `StallCount` increasing by k.
- Fault timing: `MemReady` low for TIMEOUT+1 consecutive request cycles, then `Fault=1` on the next cycle. Worst case with TIMEOUT=16 is 17 request cycles.
- `MemReady` while `MemReq=0` is ignored.
- Reset mid-MEM_WAIT drops `MemReq` in the reset cycle. Memory must tolerate the abandoned request.

## Structure
- Shared header `exec_seq_defs.vh`: state encoding localparams (3-bit) and the default TIMEOUT.
- Sub-module `exec_counter`: CNT_W-bit counter with increment enable and synchronous reset. Instantiated twice, once for retires and once for stalls.
- The FSM and waitcnt register are inline. Target size is about 150–250 lines.

## Test plan
- Reset with START_RUN=1, 4 ALU instructions → `PCEn=1` each cycle, `RetireCount=4`, `StallCount=0`.
- Load with `MemReady` low for 3 cycles → `MemReq` high 4 cycles, `PCEn` and `RegWriteEn` only in the 4th, `StallCount=3`.
- Store with TIMEOUT=4 and `MemReady` never high → `Fault=1` after 5 request cycles. `PCEn` stays 0 until reset, and reset returns to RUN.
- `HaltReq` raised during a 2-cycle load wait → load commits, then `Halted=1`. Two `StepReq` pulses give exactly 2 further commits and `Halted` stays 1.
- `HaltReq` and `StepReq` both high in HALT → STEP taken, one commit, back to HALT.
- Reset asserted in MEM_WAIT → `MemReq=0` that cycle, counters 0 next cycle.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: shared definitions for the execution sequencer.
//   state_e     - 3-bit sequencer state encoding
//   TIMEOUT_DEF - default limit on MEM_WAIT cycles before a fault
package exec_sequencer_pkg;

  typedef enum logic [2:0] {
    S_HALT     = 3'd0,
    S_RUN      = 3'd1,
    S_STEP     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FAULT    = 3'd4
  } state_e;

  localparam int unsigned TIMEOUT_DEF = 16;

endpackage

// File: rtl/exec_counter.sv
// exec_counter: free-running wrap-around counter with increment enable.
//   clk_i - clock
//   rst_i - synchronous active-high clear
//   inc_i - add one this cycle
//   cnt_o - current count (wraps modulo 2^W)
module exec_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)      cnt_q <= '0;
    else if (inc_i) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: gates PC advance and register-file write so data-memory
// accesses may take a variable number of cycles via a req/ready handshake.
// Provides halt, single-step, memory-timeout fault and retire/stall counters.
//   CLK, reset            - clock, synchronous active-high reset
//   MemRead, MemWrite     - decoded load / store
//   RegWriteIn            - decoded register write
//   MemReady              - data memory completes the access this cycle
//   HaltReq, StepReq      - halt level request, single-step pulse
//   PCEn, RegWriteEn      - commit enables (combinational)
//   MemReq, MemWE         - memory request and write qualifier (combinational)
//   Halted, Fault         - registered state flags
//   RetireCount, StallCount - committed instructions, MEM_WAIT cycles
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF,
  parameter int unsigned CNT_W     = 32,
  parameter bit          START_RUN = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             RegWriteIn,
  input  logic             MemReady,
  input  logic             HaltReq,
  input  logic             StepReq,
  output logic             PCEn,
  output logic             RegWriteEn,
  output logic             MemReq,
  output logic             MemWE,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] RetireCount,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] waitcnt_q, waitcnt_d;
  logic       orig_step_q, orig_step_d;  // access was issued from STEP
  logic       halted_q, fault_q;
  logic       commit, mreq, from_step, memop;

  always_comb begin
    memop       = MemRead | MemWrite;
    state_d     = state_q;
    waitcnt_d   = waitcnt_q;
    orig_step_d = orig_step_q;
    commit      = 1'b0;
    mreq        = 1'b0;
    from_step   = 1'b0;
    case (state_q)
      S_RUN, S_STEP: begin
        if (memop) begin
          mreq = 1'b1;
          if (MemReady) commit = 1'b1;
          else begin
            state_d     = S_MEM_WAIT;
            orig_step_d = (state_q == S_STEP);
            waitcnt_d   = 8'd1;
          end
        end else begin
          commit = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        mreq = 1'b1;
        if (MemReady)              commit    = 1'b1;
        else if (waitcnt_q == TO)  state_d   = S_FAULT;
        else                       waitcnt_d = waitcnt_q + 8'd1;
      end
      S_HALT: begin
        // Step takes priority over a released halt.
        if (StepReq)       state_d = S_STEP;
        else if (!HaltReq) state_d = S_RUN;
      end
      S_FAULT: ;
      default: state_d = S_FAULT;
    endcase
    // HaltReq is only looked at on commit, so an in-flight access finishes.
    if (commit) begin
      from_step = (state_q == S_STEP) || (state_q == S_MEM_WAIT && orig_step_q);
      state_d   = (HaltReq || from_step) ? S_HALT : S_RUN;
      waitcnt_d = 8'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= START_RUN ? S_RUN : S_HALT;
      waitcnt_q   <= 8'd0;
      orig_step_q <= 1'b0;
      halted_q    <= !START_RUN;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      waitcnt_q   <= waitcnt_d;
      orig_step_q <= orig_step_d;
      halted_q    <= (state_d == S_HALT);
      fault_q     <= (state_d == S_FAULT);
    end
  end

  // Enables are suppressed in the reset cycle, abandoning any request.
  assign PCEn       = commit & ~reset;
  assign RegWriteEn = commit & RegWriteIn & ~reset;
  assign MemReq     = mreq & ~reset;
  assign MemWE      = mreq & MemWrite & ~reset;
  assign Halted     = halted_q;
  assign Fault      = fault_q;

  exec_counter #(.W(CNT_W)) u_retire (
    .clk_i (CLK),
    .rst_i (reset),
    .inc_i (PCEn),
    .cnt_o (RetireCount)
  );

  exec_counter #(.W(CNT_W)) u_stall (
    .clk_i (CLK),
    .rst_i (reset),
    .inc_i (state_q == S_MEM_WAIT),
    .cnt_o (StallCount)
  );

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;

  localparam int CW = 32;

  logic CLK = 1'b0;
  logic reset, MemRead, MemWrite, RegWriteIn, MemReady, HaltReq, StepReq;
  logic PCEn, RegWriteEn, MemReq, MemWE, Halted, Fault;
  logic [CW-1:0] RetireCount, StallCount;

  always #5 CLK = ~CLK;

  exec_sequencer #(.TIMEOUT(4), .CNT_W(CW), .START_RUN(1'b1)) dut (
    .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWriteIn(RegWriteIn), .MemReady(MemReady), .HaltReq(HaltReq),
    .StepReq(StepReq), .PCEn(PCEn), .RegWriteEn(RegWriteEn), .MemReq(MemReq),
    .MemWE(MemWE), .Halted(Halted), .Fault(Fault),
    .RetireCount(RetireCount), .StallCount(StallCount)
  );

  typedef struct packed {
    logic          pcen, rwe, mreq, mwe, halted, fault;
    logic [CW-1:0] ret, stall;
  } exp_t;

  exp_t exp_q[$];
  int   tags[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;

  // Apply one cycle of inputs; when chk is set, queue the outputs expected
  // during that cycle.
  task automatic cyc(input bit chk, input logic rs, mr, mw, rwi, rdy, hr, sr,
                     input logic e_pc, e_rw, e_mq, e_mw, e_h, e_f,
                     input int e_ret, e_st);
    exp_t e;
    reset = rs; MemRead = mr; MemWrite = mw; RegWriteIn = rwi;
    MemReady = rdy; HaltReq = hr; StepReq = sr;
    if (chk) begin
      e = '{pcen:e_pc, rwe:e_rw, mreq:e_mq, mwe:e_mw, halted:e_h, fault:e_f,
            ret:CW'(e_ret), stall:CW'(e_st)};
      exp_q.push_back(e);
      tags.push_back(vec_no);
      vec_no++;
    end
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare observed outputs against the oldest queued expectation.
  always @(negedge CLK) begin
    exp_t a, e;
    int t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tags.pop_front();
      a = '{pcen:PCEn, rwe:RegWriteEn, mreq:MemReq, mwe:MemWE, halted:Halted,
            fault:Fault, ret:RetireCount, stall:StallCount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d: got pc=%b rw=%b mq=%b mw=%b h=%b f=%b ret=%0d st=%0d want pc=%b rw=%b mq=%b mw=%b h=%b f=%b ret=%0d st=%0d",
                 t, a.pcen, a.rwe, a.mreq, a.mwe, a.halted, a.fault, a.ret, a.stall,
                 e.pcen, e.rwe, e.mreq, e.mwe, e.halted, e.fault, e.ret, e.stall);
      end
    end
  end

  initial begin
    //   chk rs mr mw rwi rdy hr sr | pc rw mq mw h  f  ret st
    cyc(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);   // reset state
    // four ALU instructions
    cyc(1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 2, 0);
    cyc(1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 3, 0);
    // load, MemReady low 3 cycles
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 4, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 4, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 4, 1);
    cyc(1, 0, 1, 0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0, 4, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 5, 3);
    // store ready in request cycle
    cyc(1, 0, 0, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 6, 3);
    // load with 2-cycle wait, HaltReq raised during the wait
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 7, 3);
    cyc(1, 0, 1, 0, 1, 0, 1, 0,   0, 0, 1, 0, 0, 0, 7, 3);
    cyc(1, 0, 1, 0, 1, 1, 1, 0,   1, 1, 1, 0, 0, 0, 7, 4);
    cyc(1, 0, 0, 0, 1, 0, 1, 0,   0, 0, 0, 0, 1, 0, 8, 5);   // halted
    cyc(1, 0, 0, 0, 1, 0, 1, 1,   0, 0, 0, 0, 1, 0, 8, 5);   // step + halt
    cyc(1, 0, 0, 0, 1, 0, 1, 0,   1, 1, 0, 0, 0, 0, 8, 5);   // STEP commit
    cyc(1, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 9, 5);   // step, halt low
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 9, 5);   // STEP store waits
    cyc(1, 0, 0, 1, 0, 1, 0, 0,   1, 0, 1, 1, 0, 0, 9, 5);   // commit from wait
    cyc(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 0, 10, 6);  // back to HALT
    cyc(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 10, 6);  // release halt
    cyc(1, 0, 0, 0, 1, 0, 0, 1,   1, 1, 0, 0, 0, 0, 10, 6);  // step ignored in RUN
    cyc(1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 11, 6);  // commit then halt
    cyc(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 12, 6);
    // store never ready, TIMEOUT=4: 5 request cycles then fault
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 12, 6);
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 12, 6);
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 12, 7);
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 12, 8);
    cyc(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 12, 9);
    cyc(1, 0, 0, 1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 1, 12, 10); // fault, ready ignored
    cyc(1, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 12, 10);
    cyc(1, 1, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 1, 12, 10); // reset exits fault
    cyc(1, 0, 0, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    // reset during MEM_WAIT
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0);   // ready w/o request
    cyc(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
